// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU execute stage
//    ALU_WIDTH      default operand/result width
//    ALU_*          3-bit alu_control codes from the decoder
//    state_t        execute FSM encoding (IDLE, SHIFT)
//    is_shift()     true for the three shift codes
package alu_pkg;
   localparam int ALU_WIDTH = 32;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLL = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;
   localparam logic [2:0] ALU_SRA = 3'b111;
   typedef enum logic {IDLE, SHIFT} state_t;
   function automatic logic is_shift(input logic [2:0] op);
      return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
   endfunction
endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: valid/ready operand and result bus of the execute stage
//    in_valid/in_ready, a, b, alu_control          producer -> stage
//    out_valid/out_ready, result, zero, negative,
//    carry, overflow                               stage -> consumer
//    modport master: the producer/consumer side; modport slave: the stage
interface alu_exec_if
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       alu_control;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             negative;
   logic             carry;
   logic             overflow;
   modport master (
      output in_valid, a, b, alu_control, out_ready,
      input  in_ready, out_valid, result, zero, negative, carry, overflow
   );
   modport slave (
      input  in_valid, a, b, alu_control, out_ready,
      output in_ready, out_valid, result, zero, negative, carry, overflow
   );
endinterface

// File: rtl/alu_exec_shifter.sv
// alu_exec_shifter: iterative one-bit-per-cycle shifter for sll/srl/sra
//    clk, rst   clock, synchronous active-high reset
//    start      load acc=a, cnt=shamt, latch op (shamt must be nonzero)
//    op         alu_control shift code
//    a, shamt   operand and shift amount
//    next       acc shifted by one more bit (final value when done)
//    done       pulse on the last step (cnt == 1)
module alu_exec_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH   = ALU_WIDTH,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   next,
   output logic               done
);
   logic [WIDTH-1:0]   acc;
   logic [SHAMT_W-1:0] cnt;
   logic [2:0]         op_q;
   // srl and sra differ only in the fill bit entering at the top
   assign next = op_q == ALU_SLL ? {acc[WIDTH-2:0], 1'b0}
                                 : {op_q == ALU_SRA && acc[WIDTH-1], acc[WIDTH-1:1]};
   assign done = cnt == SHAMT_W'(1);
   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         cnt  <= '0;
         op_q <= ALU_ADD;
      end else if (start) begin
         acc  <= a;
         cnt  <= shamt;
         op_q <= op;
      end else if (cnt != '0) begin
         acc <= next;
         cnt <= cnt - SHAMT_W'(1);
      end
   end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: registered ALU execute stage with valid/ready handshake
//    clk, rst   clock, synchronous active-high reset
//    bus        alu_exec_if.slave: in_valid/in_ready, a, b, alu_control in;
//               out_valid/out_ready, result, zero, negative, carry, overflow out
//    ALU_EXEC_SHIFT_EN  builds the iterative shifter and SHIFT state; without
//               it the shift codes return a zero result in one cycle
module alu_exec
   import alu_pkg::*;
#(
   parameter int WIDTH   = ALU_WIDTH,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input logic       clk,
   input logic       rst,
   alu_exec_if.slave bus
);
   if (SHAMT_W != $clog2(WIDTH)) begin : g_bad_shamt
      $error("SHAMT_W must equal log2(WIDTH)");
   end
   logic [WIDTH-1:0] bx;
   logic [WIDTH-1:0] res_c;
   logic [WIDTH-1:0] res;
   logic [WIDTH:0]   sum;
   logic             use_sub;
   logic             ovf;
   logic             carry_c;
   logic             ovf_c;
   logic             idle;
   logic             accept;
   logic             start;
   logic             vld;
   logic             z;
   logic             n;
   logic             c;
   logic             v;
   // slt shares the subtractor: a + ~b + 1
   assign use_sub = bus.alu_control == ALU_SUB || bus.alu_control == ALU_SLT;
   assign bx      = use_sub ? ~bus.b : bus.b;
   assign sum     = {1'b0, bus.a} + {1'b0, bx} + (WIDTH + 1)'(use_sub);
   assign ovf     = (bus.a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
   assign accept  = bus.in_valid && bus.in_ready;
   assign bus.in_ready  = !rst && idle && (!vld || bus.out_ready);
   assign bus.out_valid = vld;
   assign bus.result    = res;
   assign bus.zero      = z;
   assign bus.negative  = n;
   assign bus.carry     = c;
   assign bus.overflow  = v;
`ifdef ALU_EXEC_SHIFT_EN
   state_t             state;
   logic [WIDTH-1:0]   sh_next;
   logic               sh_done;
   logic [SHAMT_W-1:0] shamt;
   assign shamt = bus.b[SHAMT_W-1:0];
   assign idle  = state == IDLE;
   // a zero shift amount completes like any single-cycle op
   assign start = accept && is_shift(bus.alu_control) && shamt != '0;
   alu_exec_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (bus.alu_control),
      .a     (bus.a),
      .shamt (shamt),
      .next  (sh_next),
      .done  (sh_done)
   );
`else
   assign idle  = 1'b1;
   assign start = 1'b0;
`endif
   always_comb begin
      res_c   = '0;
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      case (bus.alu_control)
         ALU_ADD, ALU_SUB: begin
            res_c   = sum[WIDTH-1:0];
            carry_c = sum[WIDTH];
            ovf_c   = ovf;
         end
         ALU_AND: res_c = bus.a & bus.b;
         ALU_OR:  res_c = bus.a | bus.b;
         ALU_SLT: res_c = WIDTH'(sum[WIDTH-1] ^ ovf);
`ifdef ALU_EXEC_SHIFT_EN
         default: res_c = bus.a;
`else
         default: res_c = '0;
`endif
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= 1'b0;
         res <= '0;
         z   <= 1'b0;
         n   <= 1'b0;
         c   <= 1'b0;
         v   <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
         state <= IDLE;
`endif
      end else begin
         if (vld && bus.out_ready) vld <= 1'b0;
         if (accept && !start) begin
            vld <= 1'b1;
            res <= res_c;
            z   <= res_c == '0;
            n   <= res_c[WIDTH-1];
            c   <= carry_c;
            v   <= ovf_c;
         end
`ifdef ALU_EXEC_SHIFT_EN
         if (start) state <= SHIFT;
         if (state == SHIFT && sh_done) begin
            vld   <= 1'b1;
            res   <= sh_next;
            z     <= sh_next == '0;
            n     <= sh_next[WIDTH-1];
            c     <= 1'b0;
            v     <= 1'b0;
            state <= IDLE;
         end
`endif
      end
   end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: randomized self-checking bench for alu_exec against a plain-arithmetic model
module tb_alu_exec;
   import alu_pkg::*;
   localparam int W = 32;
`ifdef ALU_EXEC_SHIFT_EN
   localparam bit SHIFT_EN = 1'b1;
`else
   localparam bit SHIFT_EN = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          vectors = 0;
   int          miscompares = 0;
   logic [2:0]  op;
   logic [31:0] x;
   logic [31:0] y;
   logic [35:0] expq[$];
   logic [31:0] corner [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h5555_5555};
   logic [2:0]  single [5] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};

   alu_exec_if #(.WIDTH(W)) bus ();
   alu_exec #(.WIDTH(W), .SHAMT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {result, zero, negative, carry, overflow} from the architectural definition
   function automatic logic [35:0] model(input logic [2:0] f, input logic [31:0] p, input logic [31:0] q);
      longint      sp = longint'($signed(p));
      longint      sq = longint'($signed(q));
      longint      s;
      logic [31:0] r = '0;
      logic        cy = 1'b0;
      logic        ov = 1'b0;
      int          sh = int'(q % 32);
      case (f)
         ALU_ADD: begin
            s  = sp + sq;
            r  = p + q;
            cy = longint'(p) + longint'(q) >= 64'h1_0000_0000;
            ov = s > 64'sd2147483647 || s < -64'sd2147483648;
         end
         ALU_SUB: begin
            s  = sp - sq;
            r  = p - q;
            cy = p >= q;
            ov = s > 64'sd2147483647 || s < -64'sd2147483648;
         end
         ALU_AND: r = p & q;
         ALU_OR:  r = p | q;
         ALU_SLT: r = sp < sq ? 32'd1 : 32'd0;
         ALU_SLL: if (SHIFT_EN) r = p << sh;
         ALU_SRL: if (SHIFT_EN) r = p >> sh;
         default: if (SHIFT_EN) r = $signed(p) >>> sh;
      endcase
      return {r, r == 32'd0, r[31], cy, ov};
   endfunction

   function automatic int lat_of(input logic [2:0] f, input logic [31:0] q);
      return (SHIFT_EN && is_shift(f) && q[4:0] != 5'd0) ? int'(q[4:0]) + 1 : 1;
   endfunction

   function automatic logic [35:0] obs();
      return {bus.result, bus.zero, bus.negative, bus.carry, bus.overflow};
   endfunction

   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] p, input logic [31:0] q);
      int k;
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.alu_control = f;
      bus.a           = p;
      bus.b           = q;
      k = 0;
      while (!bus.in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      check({tag, " accept"}, 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.out_valid && k < 100);
      check({tag, " latency"}, 64'(k), 64'(lat_of(f, q)));
      check({tag, " result"}, 64'(obs()), 64'(model(f, p, q)));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rises;
      bus.in_valid    = 1'b0;
      bus.out_ready   = 1'b1;
      bus.a           = '0;
      bus.b           = '0;
      bus.alu_control = ALU_ADD;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset in_ready", 64'(bus.in_ready), 64'd0);
      check("reset out_valid", 64'(bus.out_valid), 64'd0);
      check("reset outputs", 64'(obs()), 64'd0);
      rst = 1'b0;
      #1 check("post-reset in_ready", 64'(bus.in_ready), 64'd1);

      run_op("add 5+7", ALU_ADD, 32'd5, 32'd7);
      run_op("sub 7-7", ALU_SUB, 32'd7, 32'd7);
      run_op("sub 5-7", ALU_SUB, 32'd5, 32'd7);
      run_op("add ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1);
      run_op("add carry", ALU_ADD, 32'hFFFF_FFFF, 32'd1);
      run_op("slt -1<1", ALU_SLT, 32'hFFFF_FFFF, 32'd1);
      run_op("slt 1<-1", ALU_SLT, 32'd1, 32'hFFFF_FFFF);
      run_op("and", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
      run_op("or", ALU_OR, 32'hF000_0000, 32'h0000_000F);
      run_op("sll 1<<4", ALU_SLL, 32'd1, 32'd4);
      run_op("sra 31", ALU_SRA, 32'h8000_0000, 32'd31);
      run_op("srl 31", ALU_SRL, 32'h8000_0000, 32'd31);
      run_op("srl shamt0", ALU_SRL, 32'hDEAD_BEEF, 32'h0000_0020);

      // back-to-back single-cycle ops with out_ready held high
      @(negedge clk);
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) begin
            check("b2b out_valid", 64'(bus.out_valid), 64'd1);
            check("b2b result", 64'(obs()), 64'(expq.pop_front()));
         end
         if (i < 8) begin
            op = single[$urandom_range(0, 4)];
            x  = $urandom;
            y  = $urandom;
            bus.in_valid    = 1'b1;
            bus.alu_control = op;
            bus.a           = x;
            bus.b           = y;
            expq.push_back(model(op, x, y));
            check("b2b in_ready", 64'(bus.in_ready), 64'd1);
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
      end

      // backpressure: first result held, second op waits for the drain edge
      bus.out_ready   = 1'b0;
      bus.in_valid    = 1'b1;
      bus.alu_control = ALU_ADD;
      bus.a           = 32'd1;
      bus.b           = 32'd1;
      @(posedge clk);
      #1;
      bus.alu_control = ALU_SUB;
      bus.a           = 32'd9;
      bus.b           = 32'd4;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold out_valid", 64'(bus.out_valid), 64'd1);
         check("hold result", 64'(obs()), 64'(model(ALU_ADD, 32'd1, 32'd1)));
         check("hold in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      #1 check("drain in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check("drain out_valid", 64'(bus.out_valid), 64'd1);
      check("drain result", 64'(obs()), 64'(model(ALU_SUB, 32'd9, 32'd4)));

      // reset two cycles into a long shift
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.alu_control = ALU_SRA;
      bus.a           = 32'h8000_0000;
      bus.b           = 32'd10;
      check("rst-mid in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check("rst-mid early valid", 64'(bus.out_valid), 64'(!SHIFT_EN));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst-mid outputs", 64'(obs()), 64'd0);
      check("rst-mid in_ready", 64'(bus.in_ready), 64'd1);
      rises = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.out_valid) rises++;
      end
      check("rst-mid no valid", 64'(rises), 64'd0);
      run_op("add after rst", ALU_ADD, 32'd100, 32'd23);

      // randomized operations with occasional corner operands
      for (int i = 0; i < 120; i++) begin
         op = 3'($urandom_range(0, 7));
         x  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         y  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         run_op("rand", op, x, y);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
